// File: rtl/cpu_types_pkg.sv
// Shared types for the cache_control memory side: RAM state encoding,
// data word, arbiter FSM state constants and the default CPU count.
// Imported by mem_arbiter and mem_arb_pick.
package cpu_types_pkg;

   localparam int CPUS_DEF = 2;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   // Plain constants rather than an enum so older blocks can share them.
   typedef logic [1:0] arb_state_t;
   localparam arb_state_t IDLE   = 2'd0;
   localparam arb_state_t DGRANT = 2'd1;
   localparam arb_state_t IGRANT = 2'd2;

endpackage

// File: rtl/mem_arb_pick.sv
// Rotating priority picker: CPU order starts at rr, and dcache beats icache within a CPU.
// Ports: req (bit 2c = icache c, bit 2c+1 = dcache c), rr pointer in;
//        vld, owner, is_d (winner is a dcache request) out. Purely combinational.
module mem_arb_pick
   import cpu_types_pkg::*;
#(
   parameter int CPUS = CPUS_DEF,
   parameter int OW   = (CPUS > 1) ? $clog2(CPUS) : 1
) (
   input  logic [2*CPUS-1:0] req,
   input  logic [OW-1:0]     rr,
   output logic              vld,
   output logic [OW-1:0]     owner,
   output logic              is_d
);

   int c;

   // Walk from the lowest priority to the highest so the highest-priority
   // hit is written last; inside a CPU the dcache test comes after the
   // icache test so the dcache wins.
   always_comb begin
      vld   = 1'b0;
      owner = '0;
      is_d  = 1'b0;
      c     = 0;
      for (int k = CPUS - 1; k >= 0; k--) begin
         c = (int'(rr) + k) % CPUS;
         if (req[2*c]) begin
            vld   = 1'b1;
            owner = OW'(c);
            is_d  = 1'b0;
         end
         if (req[2*c+1]) begin
            vld   = 1'b1;
            owner = OW'(c);
            is_d  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Memory-side arbiter: grants one icache/dcache requester at a time onto the single RAM port.
// Ports: per-CPU iREN/iaddr/iwait/iload and dREN/dWEN/daddr/dstore/dwait/dload; ramREN/ramWEN/ramaddr/ramstore out, ramload/ramstate in.
// Macro MEM_ARB_ROUND_ROBIN_EN: defined = rotating CPU priority, undefined = fixed priority with CPU0 first.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int CPUS   = CPUS_DEF,
   parameter int DBURST = 2
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic [CPUS-1:0]      iREN,
   input  logic [CPUS-1:0][31:0] iaddr,
   output logic [CPUS-1:0]      iwait,
   output logic [CPUS-1:0][31:0] iload,
   input  logic [CPUS-1:0]      dREN,
   input  logic [CPUS-1:0]      dWEN,
   input  logic [CPUS-1:0][31:0] daddr,
   input  logic [CPUS-1:0][31:0] dstore,
   output logic [CPUS-1:0]      dwait,
   output logic [CPUS-1:0][31:0] dload,
   output logic                 ramREN,
   output logic                 ramWEN,
   output logic [31:0]          ramaddr,
   output logic [31:0]          ramstore,
   input  logic [31:0]          ramload,
   input  logic [1:0]           ramstate
);

   localparam int OW = (CPUS > 1) ? $clog2(CPUS) : 1;
   // A dcache grant ends on the ACCESS cycle seen while count holds this value.
   localparam logic [1:0] CNT_LAST = 2'(DBURST - 1);

   arb_state_t        state;
   logic [OW-1:0]     owner;
   logic [OW-1:0]     rr;
   logic [1:0]        count;

   logic [2*CPUS-1:0] req;
   logic              pick_vld;
   logic [OW-1:0]     pick_owner;
   logic              pick_d;
   logic              access;
   logic              exit_grant;

   always_comb begin
      req = '0;
      for (int c = 0; c < CPUS; c++) begin
         req[2*c]   = iREN[c];
         req[2*c+1] = dREN[c] | dWEN[c];
      end
   end

   mem_arb_pick #(.CPUS(CPUS), .OW(OW)) u_pick (
      .req   (req),
      .rr    (rr),
      .vld   (pick_vld),
      .owner (pick_owner),
      .is_d  (pick_d)
   );

   // ERROR counts as not-ACCESS: the owner simply keeps waiting.
   assign access = (ramstate == ACCESS);

   always_comb begin
      exit_grant = 1'b0;
      case (state)
         IDLE:    exit_grant = 1'b0;
         DGRANT:  exit_grant = ~(dREN[owner] | dWEN[owner]) | (access & (count == CNT_LAST));
         IGRANT:  exit_grant = ~iREN[owner] | access;
         default: exit_grant = 1'b1;   // unused encoding falls back to IDLE
      endcase
   end

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic [OW-1:0] rr_next;
   assign rr_next = (int'(owner) == CPUS - 1) ? '0 : owner + 1'b1;
`endif

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         owner <= '0;
         count <= '0;
         rr    <= '0;
      end else if (state == IDLE) begin
         if (pick_vld) begin
            owner <= pick_owner;
            state <= pick_d ? DGRANT : IGRANT;
         end
      end else begin
         if (state == DGRANT && access)
            count <= count + 2'd1;
         if (exit_grant) begin
            state <= IDLE;
            count <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr    <= rr_next;
`else
            rr    <= '0;
`endif
         end
      end
   end

   // RAM strobes are decoded from state, so an asynchronous reset drops
   // them immediately.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = '1;
      dwait    = '1;
      case (state)
         DGRANT: begin
            ramWEN        = dWEN[owner];
            ramREN        = dREN[owner] & ~dWEN[owner];
            ramaddr       = daddr[owner];
            ramstore      = dstore[owner];
            dwait[owner]  = ~access;
         end
         IGRANT: begin
            ramREN        = iREN[owner];
            ramaddr       = iaddr[owner];
            iwait[owner]  = ~access;
         end
         default: begin
         end
      endcase
   end

   // Load data is broadcast; each cache qualifies it with its own wait.
   assign iload = {CPUS{ramload}};
   assign dload = {CPUS{ramload}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand sequences
// for reset during a grant and the multi-grant fairness pattern.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   logic              CLK = 1'b0;
   logic              nRST;
   logic [1:0]        iREN, dREN, dWEN;
   logic [1:0][31:0]  iaddr, daddr, dstore;
   logic [1:0]        iwait, dwait;
   logic [1:0][31:0]  iload, dload;
   logic              ramREN, ramWEN;
   logic [31:0]       ramaddr, ramstore, ramload;
   logic [1:0]        ramstate;

   mem_arbiter dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  ir, dr, dw, st;
      logic [31:0] ofs;
      logic        ren, wen;
      logic [31:0] addr, store;
      logic [1:0]  iw, dwt;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] ir, dr, dw, st, input logic [31:0] ofs,
                               input logic ren, wen, input logic [31:0] addr, store,
                               input logic [1:0] iw, dwt);
      vec_t v;
      v.ir = ir; v.dr = dr; v.dw = dw; v.st = st; v.ofs = ofs;
      v.ren = ren; v.wen = wen; v.addr = addr; v.store = store; v.iw = iw; v.dwt = dwt;
      return v;
   endfunction

   task automatic apply(input logic [1:0] ir, dr, dw, st, input logic [31:0] ofs);
      iREN     = ir;
      dREN     = dr;
      dWEN     = dw;
      ramstate = st;
      daddr[0] = 32'h300 + ofs;
      daddr[1] = 32'h200 + ofs;
   endtask

   localparam logic [1:0] F = 2'd0, B = 2'd1, A = 2'd2, E = 2'd3;
   localparam logic [31:0] S0 = 32'hA0A0_0000, S1 = 32'hB1B1_0000;

   vec_t tbl [20];

   initial begin
      // single icache read CPU0, with an ERROR cycle standing in for BUSY
      tbl[0]  = mk(2'b01, 2'b00, 2'b00, F, 0, 0, 0, 32'h0,   0,  2'b11, 2'b11);
      tbl[1]  = mk(2'b01, 2'b00, 2'b00, B, 0, 1, 0, 32'h100, 0,  2'b11, 2'b11);
      tbl[2]  = mk(2'b01, 2'b00, 2'b00, E, 0, 1, 0, 32'h100, 0,  2'b11, 2'b11);
      tbl[3]  = mk(2'b01, 2'b00, 2'b00, A, 0, 1, 0, 32'h100, 0,  2'b11 & 2'b10, 2'b11);
      tbl[4]  = mk(2'b00, 2'b00, 2'b00, F, 0, 0, 0, 32'h0,   0,  2'b11, 2'b11);
      // dcache block read CPU1: two words, one grant
      tbl[5]  = mk(2'b00, 2'b10, 2'b00, F, 0, 0, 0, 32'h0,   0,  2'b11, 2'b11);
      tbl[6]  = mk(2'b00, 2'b10, 2'b00, A, 0, 1, 0, 32'h200, S1, 2'b11, 2'b01);
      tbl[7]  = mk(2'b00, 2'b10, 2'b00, A, 4, 1, 0, 32'h204, S1, 2'b11, 2'b01);
      tbl[8]  = mk(2'b00, 2'b00, 2'b00, F, 0, 0, 0, 32'h0,   0,  2'b11, 2'b11);
      // same-CPU contention: dcache first, icache after one IDLE cycle
      tbl[9]  = mk(2'b01, 2'b01, 2'b00, F, 0, 0, 0, 32'h0,   0,  2'b11, 2'b11);
      tbl[10] = mk(2'b01, 2'b01, 2'b00, A, 0, 1, 0, 32'h300, S0, 2'b11, 2'b10);
      tbl[11] = mk(2'b01, 2'b00, 2'b00, F, 0, 0, 0, 32'h300, S0, 2'b11, 2'b11);
      tbl[12] = mk(2'b01, 2'b00, 2'b00, F, 0, 0, 0, 32'h0,   0,  2'b11, 2'b11);
      tbl[13] = mk(2'b01, 2'b00, 2'b00, A, 0, 1, 0, 32'h100, 0,  2'b10, 2'b11);
      tbl[14] = mk(2'b00, 2'b00, 2'b00, F, 0, 0, 0, 32'h0,   0,  2'b11, 2'b11);
      // simultaneous dREN+dWEN: write wins
      tbl[15] = mk(2'b00, 2'b01, 2'b01, F, 0, 0, 0, 32'h0,   0,  2'b11, 2'b11);
      tbl[16] = mk(2'b00, 2'b01, 2'b01, B, 0, 0, 1, 32'h300, S0, 2'b11, 2'b11);
      tbl[17] = mk(2'b00, 2'b01, 2'b01, A, 0, 0, 1, 32'h300, S0, 2'b11, 2'b10);
      tbl[18] = mk(2'b00, 2'b00, 2'b00, F, 0, 0, 0, 32'h300, S0, 2'b11, 2'b11);
      tbl[19] = mk(2'b00, 2'b00, 2'b00, F, 0, 0, 0, 32'h0,   0,  2'b11, 2'b11);

      nRST      = 1'b0;
      iaddr[0]  = 32'h100;
      iaddr[1]  = 32'h1100;
      dstore[0] = S0;
      dstore[1] = S1;
      ramload   = 32'hDEAD_BEEF;
      apply(2'b00, 2'b00, 2'b00, F, 0);

      // reset state
      repeat (2) @(negedge CLK);
      chk("rst ramREN",  {31'b0, ramREN}, 0);
      chk("rst ramWEN",  {31'b0, ramWEN}, 0);
      chk("rst ramaddr", ramaddr, 0);
      chk("rst ramstore", ramstore, 0);
      chk("rst iwait",   {30'b0, iwait}, 32'h3);
      chk("rst dwait",   {30'b0, dwait}, 32'h3);
      nRST = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         apply(tbl[i].ir, tbl[i].dr, tbl[i].dw, tbl[i].st, tbl[i].ofs);
         #1;
         chk($sformatf("row%0d ramREN", i),   {31'b0, ramREN}, {31'b0, tbl[i].ren});
         chk($sformatf("row%0d ramWEN", i),   {31'b0, ramWEN}, {31'b0, tbl[i].wen});
         chk($sformatf("row%0d ramaddr", i),  ramaddr, tbl[i].addr);
         chk($sformatf("row%0d ramstore", i), ramstore, tbl[i].store);
         chk($sformatf("row%0d iwait", i),    {30'b0, iwait}, {30'b0, tbl[i].iw});
         chk($sformatf("row%0d dwait", i),    {30'b0, dwait}, {30'b0, tbl[i].dwt});
         if (tbl[i].st == A)
            chk($sformatf("row%0d load", i), iload[0], 32'hDEAD_BEEF);
      end

      // reset mid-grant after one ACCESS cycle
      @(negedge CLK); apply(2'b00, 2'b01, 2'b00, F, 0);
      @(negedge CLK); apply(2'b00, 2'b01, 2'b00, A, 0); #1;
      chk("rg dwait acc", {30'b0, dwait}, 32'h2);
      @(negedge CLK); apply(2'b00, 2'b01, 2'b00, B, 0); #1;
      chk("rg ramREN held", {31'b0, ramREN}, 1);
      nRST = 1'b0; #1;
      chk("rg ramREN async", {31'b0, ramREN}, 0);
      chk("rg ramWEN async", {31'b0, ramWEN}, 0);
      chk("rg ramaddr", ramaddr, 0);
      chk("rg iwait",   {30'b0, iwait}, 32'h3);
      chk("rg dwait",   {30'b0, dwait}, 32'h3);
      @(negedge CLK); apply(2'b00, 2'b00, 2'b00, F, 0); nRST = 1'b1;
      @(negedge CLK); apply(2'b10, 2'b00, 2'b00, F, 0); #1;
      chk("rg idle ramREN", {31'b0, ramREN}, 0);
      @(negedge CLK); apply(2'b10, 2'b00, 2'b00, A, 0); #1;
      chk("rg regrant ramREN", {31'b0, ramREN}, 1);
      chk("rg regrant addr", ramaddr, 32'h1100);
      chk("rg regrant iwait", {30'b0, iwait}, 32'h1);
      @(negedge CLK); apply(2'b00, 2'b00, 2'b00, F, 0); #1;
      chk("rg exit ramREN", {31'b0, ramREN}, 0);

      // both dcaches write continuously: IDLE + 2 ACCESS cycles per grant
      for (int cyc = 0; cyc < 9; cyc++) begin
         int g, own;
         @(negedge CLK);
         apply(2'b00, 2'b00, 2'b11, A, 0);
         ramload = 32'hC0DE_0000 + cyc;
         #1;
         g = cyc / 3;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         own = g % 2;
`else
         own = 0;
`endif
         if (cyc % 3 == 0) begin
            chk($sformatf("fair%0d idle wen", cyc), {31'b0, ramWEN}, 0);
            chk($sformatf("fair%0d idle addr", cyc), ramaddr, 0);
         end else begin
            chk($sformatf("fair%0d wen", cyc), {31'b0, ramWEN}, 1);
            chk($sformatf("fair%0d addr", cyc), ramaddr, (own == 1) ? 32'h200 : 32'h300);
            chk($sformatf("fair%0d dwait", cyc), {30'b0, dwait}, (own == 1) ? 32'h1 : 32'h2);
            chk($sformatf("fair%0d dload", cyc), dload[own], 32'hC0DE_0000 + cyc);
            chk($sformatf("fair%0d iload1", cyc), iload[1], 32'hC0DE_0000 + cyc);
         end
      end
      @(negedge CLK); apply(2'b00, 2'b00, 2'b00, F, 0);
      @(negedge CLK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
